tm1638_frame_buf: RTL and testbench
===================================

// Module: tm1638_frame_buf
// PURPOSE
//   Display frame buffer between the BCD time counter and the TM1638 serial driver.
//   Snapshots the six BCD digits at each display refresh and converts them to 7-seg bytes.
//   Serves bytes to the driver by TM1638 display address over a 1-cycle read port.
//   Adds blinking separators, hour leading-zero blanking and a running seconds LED.
// PARAMETERS
//   CLK_HZ    50_000_000  clk_50M frequency in Hz
//   BLINK_HZ  1           separator blink rate; one full on+off period per 1/BLINK_HZ s
//   LZB       1           1 = blank hour tens digit when it is 0
// PORTS
//   clk_50M     in   1  system clock
//   reset       in   1  asynchronous, active-low reset
//   hour_chuc   in   4  BCD hour tens
//   hour_dv     in   4  BCD hour units
//   min_chuc    in   4  BCD minute tens
//   min_dv      in   4  BCD minute units
//   sec_chuc    in   4  BCD second tens
//   sec_dv      in   4  BCD second units
//   blink_en    in   1  1 = separators blink, 0 = separators always lit
//   frame_start in   1  1-cycle pulse from driver at start of each refresh frame
//   rd_req      in   1  read request, one per cycle max, back-to-back allowed
//   rd_addr     in   4  TM1638 address 0..15 (even = digit, odd = LED)
//   rd_data     out  8  byte for the address requested one cycle earlier
//   rd_valid    out  1  rd_data valid, asserted exactly 1 cycle after rd_req
// BEHAVIOUR
//   Reset (reset=0, async): snapshot digits=0, blink_phase=0, blink_cnt=0, rd_data=8'h00, rd_valid=0.
//   Blink timer: blink_cnt counts 0..CLK_HZ/(2*BLINK_HZ)-1, then wraps to 0 and toggles blink_phase.
//     Timer free-runs and is independent of frame_start.
//   Snapshot: on a clk_50M edge with frame_start=1, latch all six digits and blink_phase into shadow regs.
//     Between frame_starts the shadow regs hold, so input changes never tear a frame.
//   Read port: on a clk_50M edge with rd_req=1, register rd_data from the shadow regs and set rd_valid=1.
//     Otherwise rd_valid=0 and rd_data holds its last value. Latency is exactly 1 cycle, no stalls.
//   frame_start and rd_req in the same cycle: the read uses the OLD shadow values.
//     The new snapshot applies to reads from the next cycle.
//   Digit map, even address 2k, k=0..7:
//     k=0 hour_chuc, k=1 hour_dv, k=2 separator, k=3 min_chuc, k=4 min_dv,
//     k=5 separator, k=6 sec_chuc, k=7 sec_dv.
//   Seg encoding, common cathode, bit0=a..bit6=g, bit7=dp always 0:
//     0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F.
//   Invalid BCD 10..15 -> 8'h79 ('E'). No clamping or correction.
//   Separator: 8'h40 (dash); 8'h00 when blink_en=1 and shadow blink_phase=1.
//     blink_en is sampled live at the read, not snapshotted.
//   LZB=1 and shadow hour_chuc==0 -> k=0 returns 8'h00. Other digits are never blanked.
//   LED map, odd address 2k+1: 8'h01 if k == shadow sec_dv[2:0], else 8'h00.
//     sec_dv 8 or 9 wraps to LED 0 or 1.
//   Reset mid-frame: outputs clear immediately. The first read after release returns snapshot 0.
//     Hour tens reads 8'h00 if LZB=1. Digits read 3F until the next frame_start.
// TESTING
//   1) Reset, frame_start with time 12:34:56, read addr 0..14 even ->
//      06,5B,40,4F,66,40,6D,7D; rd_valid 1 cycle after each rd_req.
//   2) Time 09:05:07 with LZB=1 -> addr0=00, addr2=6F. Same time with LZB=0 -> addr0=3F.
//   3) Snapshot 12:34:56, change inputs to 23:59:59 with no frame_start ->
//      addr14 still 7D. After frame_start, addr14=6F.
//   4) CLK_HZ=20, BLINK_HZ=1, blink_en=1 -> addr4 alternates 40/00 every 10 cycles across frames.
//      blink_en=0 -> always 40.
//   5) frame_start and rd_req(addr 14) in the same cycle -> old value returned; next read returns new value.
//      sec_dv=3 -> addr7=01, other odd addresses=00.
//   6) hour_dv=4'hB -> addr2=79. Assert reset mid-burst -> rd_valid=0 and rd_data=00 asynchronously.

Source files
------------

// File: rtl/tm1638_frame_buf.sv
// Display frame buffer for the TM1638 driver: snapshots BCD time digits per
// refresh frame and serves 7-seg / LED bytes over a 1-cycle read port.
module tm1638_frame_buf #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BLINK_HZ = 1,
    parameter bit LZB      = 1'b1
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic [3:0] hour_chuc,
    input  logic [3:0] hour_dv,
    input  logic [3:0] min_chuc,
    input  logic [3:0] min_dv,
    input  logic [3:0] sec_chuc,
    input  logic [3:0] sec_dv,
    input  logic       blink_en,
    input  logic       frame_start,
    input  logic       rd_req,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       rd_valid
);

    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(HALF - 1);

    localparam logic [7:0] SEP_ON  = 8'h40;
    localparam logic [7:0] BLANK   = 8'h00;
    localparam logic [7:0] SEG_ERR = 8'h79;

    // Blink timer
    logic [CW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic          blink_wrap;

    // Shadow copy of the frame; index 0 = hour tens .. 5 = second units
    logic [5:0][3:0] sh_dig_q, sh_dig_d;
    logic            sh_phase_q, sh_phase_d;

    // Read port
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_byte;
    logic [2:0] k;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = SEG_ERR;
        endcase
        return s;
    endfunction

    always_comb begin
        blink_wrap    = (blink_cnt_q == CNT_MAX);
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q ^ blink_wrap;
    end

    always_comb begin
        sh_dig_d   = sh_dig_q;
        sh_phase_d = sh_phase_q;
        if (frame_start) begin
            sh_dig_d   = {sec_dv, sec_chuc, min_dv, min_chuc, hour_dv, hour_chuc};
            sh_phase_d = blink_phase_q;
        end
    end

    // Reads see the shadow before any same-cycle snapshot update
    always_comb begin
        k       = rd_addr[3:1];
        rd_byte = BLANK;
        if (rd_addr[0]) begin
            rd_byte = (k == sh_dig_q[5][2:0]) ? 8'h01 : BLANK;
        end else begin
            case (k)
                3'd0: begin
                    if (LZB && sh_dig_q[0] == 4'd0)
                        rd_byte = BLANK;
                    else
                        rd_byte = seg7(sh_dig_q[0]);
                end
                3'd1:    rd_byte = seg7(sh_dig_q[1]);
                3'd3:    rd_byte = seg7(sh_dig_q[2]);
                3'd4:    rd_byte = seg7(sh_dig_q[3]);
                3'd6:    rd_byte = seg7(sh_dig_q[4]);
                3'd7:    rd_byte = seg7(sh_dig_q[5]);
                default: rd_byte = (blink_en && sh_phase_q) ? BLANK : SEP_ON;
            endcase
        end
    end

    always_comb begin
        rd_valid_d = rd_req;
        rd_data_d  = rd_req ? rd_byte : rd_data_q;
    end

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            sh_dig_q      <= '0;
            sh_phase_q    <= 1'b0;
            rd_data_q     <= 8'h00;
            rd_valid_q    <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            sh_dig_q      <= sh_dig_d;
            sh_phase_q    <= sh_phase_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_tm1638_frame_buf.sv
// Testbench for tm1638_frame_buf: directed scenarios plus randomized traffic
// checked against a behavioural frame model.
module tb_tm1638_frame_buf;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] hour_chuc = '0, hour_dv = '0, min_chuc = '0;
    logic [3:0] min_dv = '0, sec_chuc = '0, sec_dv = '0;
    logic       blink_en = 1'b0;
    logic       frame_start = 1'b0;
    logic       rd_req = 1'b0;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data, rd_data0;
    logic       rd_valid, rd_valid0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tm1638_frame_buf #(.CLK_HZ(20), .BLINK_HZ(1), .LZB(1'b1)) dut (
        .clk_50M(clk), .reset(reset),
        .hour_chuc(hour_chuc), .hour_dv(hour_dv),
        .min_chuc(min_chuc), .min_dv(min_dv),
        .sec_chuc(sec_chuc), .sec_dv(sec_dv),
        .blink_en(blink_en), .frame_start(frame_start),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    tm1638_frame_buf #(.CLK_HZ(20), .BLINK_HZ(1), .LZB(1'b0)) dut0 (
        .clk_50M(clk), .reset(reset),
        .hour_chuc(hour_chuc), .hour_dv(hour_dv),
        .min_chuc(min_chuc), .min_dv(min_dv),
        .sec_chuc(sec_chuc), .sec_dv(sec_dv),
        .blink_en(blink_en), .frame_start(frame_start),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_valid(rd_valid0)
    );

    // Reference model: six snapshotted digits, blink phase from elapsed cycles
    logic [3:0] m_dig [0:5];
    logic       m_ph;
    int         edges;
    logic       exp_valid;
    logic [7:0] exp_data, exp_data0;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] tbl [0:9];
        tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        if (d > 4'd9) return 8'h79;
        return tbl[d];
    endfunction

    function automatic logic [7:0] ref_byte(input logic [3:0] a,
                                            input bit lzb,
                                            input logic ben);
        int k;
        int dmap [0:7];
        dmap = '{0, 1, -1, 2, 3, -1, 4, 5};
        k = int'(a) / 2;
        if (a[0]) return (k == int'(m_dig[5]) % 8) ? 8'h01 : 8'h00;
        if (dmap[k] < 0) return (ben && m_ph) ? 8'h00 : 8'h40;
        if (k == 0 && lzb && m_dig[0] == 4'd0) return 8'h00;
        return seg_of(m_dig[dmap[k]]);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 6; i++) m_dig[i] <= 4'd0;
            m_ph      <= 1'b0;
            edges     <= 0;
            exp_valid <= 1'b0;
            exp_data  <= 8'h00;
            exp_data0 <= 8'h00;
        end else begin
            edges     <= edges + 1;
            exp_valid <= rd_req;
            if (rd_req) begin
                exp_data  <= ref_byte(rd_addr, 1'b1, blink_en);
                exp_data0 <= ref_byte(rd_addr, 1'b0, blink_en);
            end
            if (frame_start) begin
                m_dig[0] <= hour_chuc;
                m_dig[1] <= hour_dv;
                m_dig[2] <= min_chuc;
                m_dig[3] <= min_dv;
                m_dig[4] <= sec_chuc;
                m_dig[5] <= sec_dv;
                m_ph     <= ((edges / 10) % 2) == 1;
            end
        end
    end

    task automatic set_time(input int h, input int m, input int s);
        hour_chuc = 4'(h / 10); hour_dv = 4'(h % 10);
        min_chuc  = 4'(m / 10); min_dv  = 4'(m % 10);
        sec_chuc  = 4'(s / 10); sec_dv  = 4'(s % 10);
    endtask

    // Drive one cycle of stimulus and return at the following negedge
    task automatic step(input logic fs, input logic req, input logic [3:0] a);
        frame_start = fs;
        rd_req      = req;
        rd_addr     = a;
        @(negedge clk);
        frame_start = 1'b0;
        rd_req      = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (rd_valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid got %b want 0", rd_valid);
        end
        tests++;
        if (rd_data !== 8'h00) begin
            fails++; $display("FAIL reset_data got %h want 00", rd_data);
        end
        reset = 1'b1;
        step(1'b0, 1'b1, 4'd0);
        tests++;
        if (rd_data !== 8'h00 || rd_data0 !== 8'h3F) begin
            fails++;
            $display("FAIL reset_addr0 got %h/%h want 00/3F", rd_data, rd_data0);
        end
        step(1'b0, 1'b1, 4'd2);
        tests++;
        if (rd_data !== 8'h3F) begin
            fails++; $display("FAIL reset_addr2 got %h want 3F", rd_data);
        end
    endtask

    task automatic test_basic;
        logic [7:0] want [0:7];
        want = '{8'h06, 8'h5B, 8'h40, 8'h4F, 8'h66, 8'h40, 8'h6D, 8'h7D};
        blink_en = 1'b0;
        set_time(12, 34, 56);
        step(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 4'(2 * i));
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== want[i]) begin
                fails++;
                $display("FAIL basic_addr%0d got %h v=%b want %h v=1",
                         2 * i, rd_data, rd_valid, want[i]);
            end
        end
        step(1'b0, 1'b0, 4'd0);
        tests++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h7D) begin
            fails++;
            $display("FAIL basic_idle got %h v=%b want 7D v=0", rd_data, rd_valid);
        end
    endtask

    task automatic test_lzb;
        set_time(9, 5, 7);
        step(1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'd0);
        tests++;
        if (rd_data !== 8'h00 || rd_data0 !== 8'h3F) begin
            fails++;
            $display("FAIL lzb_addr0 got %h/%h want 00/3F", rd_data, rd_data0);
        end
        step(1'b0, 1'b1, 4'd2);
        tests++;
        if (rd_data !== 8'h6F) begin
            fails++; $display("FAIL lzb_addr2 got %h want 6F", rd_data);
        end
    endtask

    task automatic test_snapshot;
        set_time(12, 34, 56);
        step(1'b1, 1'b0, 4'd0);
        set_time(23, 59, 59);
        repeat (3) step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'd14);
        tests++;
        if (rd_data !== 8'h7D) begin
            fails++; $display("FAIL snap_hold got %h want 7D", rd_data);
        end
        step(1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'd14);
        tests++;
        if (rd_data !== 8'h6F) begin
            fails++; $display("FAIL snap_new got %h want 6F", rd_data);
        end
    endtask

    task automatic test_blink;
        int n_on = 0;
        int n_off = 0;
        blink_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 4'd0);
            step(1'b0, 1'b1, 4'd4);
            tests++;
            if (rd_data !== exp_data) begin
                fails++;
                $display("FAIL blink_on%0d got %h want %h", i, rd_data, exp_data);
            end
            if (rd_data === 8'h40) n_on++;
            if (rd_data === 8'h00) n_off++;
        end
        tests++;
        if (n_on == 0 || n_off == 0) begin
            fails++;
            $display("FAIL blink_toggle got on=%0d off=%0d want both >0", n_on, n_off);
        end
        blink_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 4'd10);
            tests++;
            if (rd_data !== 8'h40) begin
                fails++; $display("FAIL blink_off%0d got %h want 40", i, rd_data);
            end
        end
    endtask

    task automatic test_same_cycle;
        set_time(12, 34, 56);
        step(1'b1, 1'b0, 4'd0);
        set_time(23, 59, 59);
        step(1'b1, 1'b1, 4'd14);
        tests++;
        if (rd_data !== 8'h7D) begin
            fails++; $display("FAIL same_old got %h want 7D", rd_data);
        end
        step(1'b0, 1'b1, 4'd14);
        tests++;
        if (rd_data !== 8'h6F) begin
            fails++; $display("FAIL same_new got %h want 6F", rd_data);
        end
        set_time(10, 20, 33);
        step(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 4'(2 * i + 1));
            tests++;
            if (rd_data !== ((i == 3) ? 8'h01 : 8'h00)) begin
                fails++;
                $display("FAIL led_addr%0d got %h want %h", 2 * i + 1, rd_data,
                         (i == 3) ? 8'h01 : 8'h00);
            end
        end
    endtask

    task automatic test_invalid_and_reset;
        set_time(12, 34, 56);
        hour_dv = 4'hB;
        step(1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'd2);
        tests++;
        if (rd_data !== 8'h79) begin
            fails++; $display("FAIL invalid_bcd got %h want 79", rd_data);
        end
        step(1'b0, 1'b1, 4'd12);
        rd_req  = 1'b1;
        rd_addr = 4'd14;
        #2 reset = 1'b0;
        #1;
        tests++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            fails++;
            $display("FAIL async_reset got %h v=%b want 00 v=0", rd_data, rd_valid);
        end
        rd_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b1, 4'd0);
        tests++;
        if (rd_data !== 8'h00 || rd_data0 !== 8'h3F) begin
            fails++;
            $display("FAIL post_reset0 got %h/%h want 00/3F", rd_data, rd_data0);
        end
        step(1'b0, 1'b1, 4'd6);
        tests++;
        if (rd_data !== 8'h3F) begin
            fails++; $display("FAIL post_reset6 got %h want 3F", rd_data);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                hour_chuc = 4'($urandom_range(0, 15));
                hour_dv   = 4'($urandom_range(0, 15));
            end else begin
                hour_chuc = 4'($urandom_range(0, 2));
                hour_dv   = 4'($urandom_range(0, 9));
            end
            min_chuc = 4'($urandom_range(0, 5));
            min_dv   = 4'($urandom_range(0, 9));
            sec_chuc = 4'($urandom_range(0, 5));
            sec_dv   = 4'($urandom_range(0, 9));
            blink_en = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)));
            tests++;
            if (rd_valid !== exp_valid || rd_data !== exp_data ||
                rd_data0 !== exp_data0) begin
                fails++;
                $display("FAIL rand%0d got %h/%h v=%b want %h/%h v=%b", i,
                         rd_data, rd_data0, rd_valid, exp_data, exp_data0, exp_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lzb();
        test_snapshot();
        test_blink();
        test_same_cycle();
        test_invalid_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
